// File: rtl/rapid_pkg.sv
// rtl/rapid_pkg.sv - shared constants and issue FSM state type for the decode/issue slice
package rapid_pkg;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;
    localparam int REG_AW   = $clog2(NUM_REGS);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_DE = 3'd1,
        CHECK   = 3'd2,
        ISSUE   = 3'd3,
        DRAIN   = 3'd4
    } issue_state_t;

endpackage

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - register busy scoreboard with combinational three-index hazard query
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   set_en, set_idx      mark a register busy (ignored for x0)
//   clr_en, clr_idx      retire a register (writeback)
//   q1/q2/q3_en, _idx    operand/destination indices to test against busy
//   hazard               any enabled query hits a busy register (after this cycle's clear)
module issue_scoreboard
    import rapid_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_idx,
    input  logic              clr_en,
    input  logic [REG_AW-1:0] clr_idx,
    input  logic              q1_en,
    input  logic [REG_AW-1:0] q1_idx,
    input  logic              q2_en,
    input  logic [REG_AW-1:0] q2_idx,
    input  logic              q3_en,
    input  logic [REG_AW-1:0] q3_idx,
    output logic              hazard
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] busy_byp;
    logic [NUM_REGS-1:0] busy_d;

    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (clr_en) clr_mask[clr_idx] = 1'b1;
        if (set_en) set_mask[set_idx] = 1'b1;
        // Queries see the register already retired this cycle.
        busy_byp = busy_q & ~clr_mask;
        // Set is applied after clear so a same-cycle set/clear leaves the bit set.
        busy_d   = busy_byp | set_mask;
        hazard   = (q1_en && busy_byp[q1_idx]) ||
                   (q2_en && busy_byp[q2_idx]) ||
                   (q3_en && busy_byp[q3_idx]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= {busy_d[NUM_REGS-1:1], 1'b0};
        end
    end

endmodule

// File: rtl/decode_issue_ctrl.sv
// rtl/decode_issue_ctrl.sv - sequences the decoder and issues to EX under scoreboard hazard control
//
// Ports:
//   i_clk, i_reset                 clock, asynchronous active-high reset
//   i_if_valid / o_if_ack          fetch handshake (ack is a one-cycle pulse)
//   o_de_start / i_de_done         decoder start pulse and completion
//   i_de_pc, i_rs1, i_rs2, i_rd    decoded payload, with i_rs1_used, i_rs2_used, i_rd_we flags
//   o_issue_valid / i_ex_ready     issue handshake to EX, payload o_issue_pc / o_issue_rd
//   i_wb_valid, i_wb_rd            writeback retiring a register
//   i_flush                        discard the instruction in flight
//   o_state                        current issue_state_t
//   o_issue_cnt, o_stall_cnt       only with ISSUE_PERF_CNT_EN: accepted issues, hazard stall cycles
module decode_issue_ctrl
    import rapid_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_if_valid,
    output logic              o_if_ack,
    output logic              o_de_start,
    input  logic              i_de_done,
    input  logic [XLEN-1:0]   i_de_pc,
    input  logic [REG_AW-1:0] i_rs1,
    input  logic [REG_AW-1:0] i_rs2,
    input  logic [REG_AW-1:0] i_rd,
    input  logic              i_rs1_used,
    input  logic              i_rs2_used,
    input  logic              i_rd_we,
    output logic              o_issue_valid,
    input  logic              i_ex_ready,
    output logic [XLEN-1:0]   o_issue_pc,
    output logic [REG_AW-1:0] o_issue_rd,
    input  logic              i_wb_valid,
    input  logic [REG_AW-1:0] i_wb_rd,
    input  logic              i_flush,
`ifdef ISSUE_PERF_CNT_EN
    output logic [31:0]       o_issue_cnt,
    output logic [31:0]       o_stall_cnt,
`endif
    output logic [2:0]        o_state
);

    issue_state_t      state_q, state_d;
    logic              start_q, start_d;
    logic              latch;
    logic              accept;
    logic              hazard;
    logic [REG_AW-1:0] rs1_q, rs2_q;
    logic              rs1_used_q, rs2_used_q, rd_we_q;

    issue_scoreboard u_sb (
        .clk     (i_clk),
        .rst     (i_reset),
        .set_en  (accept && rd_we_q),
        .set_idx (o_issue_rd),
        .clr_en  (i_wb_valid),
        .clr_idx (i_wb_rd),
        .q1_en   (rs1_used_q),
        .q1_idx  (rs1_q),
        .q2_en   (rs2_used_q),
        .q2_idx  (rs2_q),
        .q3_en   (rd_we_q),
        .q3_idx  (o_issue_rd),
        .hazard  (hazard)
    );

    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        latch   = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!i_flush && i_if_valid) begin
                    state_d = WAIT_DE;
                    start_d = 1'b1;
                end
            end
            WAIT_DE: begin
                // A flush coinciding with done already consumes the decoder result.
                if (i_flush) begin
                    state_d = i_de_done ? IDLE : DRAIN;
                end else if (i_de_done) begin
                    latch   = 1'b1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (i_flush)      state_d = IDLE;
                else if (!hazard) state_d = ISSUE;
            end
            ISSUE: begin
                if (i_flush) begin
                    state_d = IDLE;
                end else if (i_ex_ready) begin
                    accept  = 1'b1;
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (i_de_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= IDLE;
            start_q    <= 1'b0;
            o_issue_pc <= '0;
            o_issue_rd <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rs1_used_q <= 1'b0;
            rs2_used_q <= 1'b0;
            rd_we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            if (latch) begin
                o_issue_pc <= i_de_pc;
                o_issue_rd <= i_rd;
                rs1_q      <= i_rs1;
                rs2_q      <= i_rs2;
                rs1_used_q <= i_rs1_used;
                rs2_used_q <= i_rs2_used;
                rd_we_q    <= i_rd_we;
            end
        end
    end

`ifdef ISSUE_PERF_CNT_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_issue_cnt <= '0;
            o_stall_cnt <= '0;
        end else begin
            if (accept) o_issue_cnt <= o_issue_cnt + 32'd1;
            if (state_q == CHECK && hazard) o_stall_cnt <= o_stall_cnt + 32'd1;
        end
    end
`endif

    assign o_if_ack      = start_q;
    assign o_de_start    = start_q;
    assign o_issue_valid = (state_q == ISSUE);
    assign o_state       = state_q;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// tb/tb_decode_issue_ctrl.sv - self-checking bench for decode_issue_ctrl
module tb_decode_issue_ctrl;
    import rapid_pkg::*;

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic              i_if_valid;
    logic              o_if_ack;
    logic              o_de_start;
    logic              i_de_done;
    logic [XLEN-1:0]   i_de_pc;
    logic [REG_AW-1:0] i_rs1, i_rs2, i_rd;
    logic              i_rs1_used, i_rs2_used, i_rd_we;
    logic              o_issue_valid;
    logic              i_ex_ready;
    logic [XLEN-1:0]   o_issue_pc;
    logic [REG_AW-1:0] o_issue_rd;
    logic              i_wb_valid;
    logic [REG_AW-1:0] i_wb_rd;
    logic              i_flush;
    logic [2:0]        o_state;
`ifdef ISSUE_PERF_CNT_EN
    logic [31:0]       o_issue_cnt, o_stall_cnt;
`endif

    decode_issue_ctrl dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_if_valid(i_if_valid), .o_if_ack(o_if_ack),
        .o_de_start(o_de_start), .i_de_done(i_de_done), .i_de_pc(i_de_pc),
        .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd), .i_rs1_used(i_rs1_used),
        .i_rs2_used(i_rs2_used), .i_rd_we(i_rd_we), .o_issue_valid(o_issue_valid),
        .i_ex_ready(i_ex_ready), .o_issue_pc(o_issue_pc), .o_issue_rd(o_issue_rd),
        .i_wb_valid(i_wb_valid), .i_wb_rd(i_wb_rd), .i_flush(i_flush),
`ifdef ISSUE_PERF_CNT_EN
        .o_issue_cnt(o_issue_cnt), .o_stall_cnt(o_stall_cnt),
`endif
        .o_state(o_state)
    );

    always #5 i_clk = ~i_clk;

    int vectors = 0;
    int errors  = 0;
    int dec_cnt = -1;

    // Reference model: where the instruction is, what it holds, which registers are pending.
    issue_state_t m_state;
    bit           m_start;
    bit [31:0]    m_busy;
    bit [31:0]    m_pc;
    bit [4:0]     m_rs1, m_rs2, m_rd;
    bit           m_u1, m_u2, m_we;
    int unsigned  m_issues, m_stalls;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = IDLE; m_start = 0; m_busy = '0; m_pc = '0;
        m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_u1 = 0; m_u2 = 0; m_we = 0;
        m_issues = 0; m_stalls = 0;
    endtask

    task automatic model_advance();
        bit [31:0]    pending;
        bit           hz;
        issue_state_t nxt;
        bit           nstart;
        pending = m_busy;
        if (i_wb_valid) pending[i_wb_rd] = 1'b0;
        hz = (m_u1 && pending[m_rs1]) || (m_u2 && pending[m_rs2]) || (m_we && pending[m_rd]);
        nxt = m_state;
        nstart = 0;
        case (m_state)
            IDLE:    if (!i_flush && i_if_valid) begin nxt = WAIT_DE; nstart = 1; end
            WAIT_DE: begin
                if (i_flush) nxt = i_de_done ? IDLE : DRAIN;
                else if (i_de_done) begin
                    nxt = CHECK; m_pc = i_de_pc; m_rs1 = i_rs1; m_rs2 = i_rs2; m_rd = i_rd;
                    m_u1 = i_rs1_used; m_u2 = i_rs2_used; m_we = i_rd_we;
                end
            end
            CHECK: begin
                if (hz) m_stalls++;
                if (i_flush) nxt = IDLE;
                else if (!hz) nxt = ISSUE;
            end
            ISSUE: begin
                if (i_flush) nxt = IDLE;
                else if (i_ex_ready) begin
                    m_issues++;
                    if (m_we && m_rd != 0) pending[m_rd] = 1'b1;
                    nxt = IDLE;
                end
            end
            DRAIN:   if (i_de_done) nxt = IDLE;
            default: nxt = IDLE;
        endcase
        m_busy = pending; m_state = nxt; m_start = nstart;
    endtask

    task automatic compare_all();
        check("state", o_state, m_state);
        check("de_start", o_de_start, m_start);
        check("if_ack", o_if_ack, m_start);
        check("issue_valid", o_issue_valid, m_state == ISSUE);
        if (m_state == ISSUE) begin
            check("issue_pc", o_issue_pc, m_pc);
            check("issue_rd", o_issue_rd, m_rd);
        end
        check("busy", dut.u_sb.busy_q, m_busy);
`ifdef ISSUE_PERF_CNT_EN
        check("issue_cnt", o_issue_cnt, m_issues);
        check("stall_cnt", o_stall_cnt, m_stalls);
`endif
    endtask

    task automatic cycle();
        model_advance();
        @(posedge i_clk);
        @(negedge i_clk);
        compare_all();
    endtask

    task automatic clear_inputs();
        i_if_valid = 0; i_de_done = 0; i_de_pc = '0; i_rs1 = '0; i_rs2 = '0; i_rd = '0;
        i_rs1_used = 0; i_rs2_used = 0; i_rd_we = 0; i_ex_ready = 0;
        i_wb_valid = 0; i_wb_rd = '0; i_flush = 0;
    endtask

    task automatic set_regs(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                            input logic u1, input logic u2, input logic we, input logic [31:0] pc);
        i_rs1 = rs1; i_rs2 = rs2; i_rd = rd;
        i_rs1_used = u1; i_rs2_used = u2; i_rd_we = we; i_de_pc = pc;
    endtask

    task automatic set_insn(input logic [31:0] insn, input logic [31:0] pc,
                            input logic u1, input logic u2, input logic we);
        set_regs(insn[19:15], insn[24:20], insn[11:7], u1, u2, we, pc);
    endtask

    initial begin
        clear_inputs();
        model_reset();
        i_reset = 1;
        i_if_valid = 1;
        repeat (2) begin
            @(posedge i_clk);
            @(negedge i_clk);
            compare_all();
        end
        check("t1_rst_valid", o_issue_valid, 0);
        check("t1_rst_start", o_de_start, 0);
        i_reset = 0;

        // Fetch handshake: single start/ack pulse.
        cycle();
        check("t1_state", o_state, WAIT_DE);
        check("t1_start", o_de_start, 1);
        check("t1_ack", o_if_ack, 1);
        i_if_valid = 0;
        cycle();
        check("t1_pulse_once", o_de_start, 0);

        // addi x12,x0,5 issues two cycles after done.
        set_insn(32'h00500613, 32'h20, 1, 0, 1);
        i_de_done = 1; i_ex_ready = 1;
        cycle();
        i_de_done = 0;
        check("t2_lat1", o_issue_valid, 0);
        cycle();
        check("t2_valid", o_issue_valid, 1);
        check("t2_pc", o_issue_pc, 32'h20);
        check("t2_rd", o_issue_rd, 12);
        cycle();
        check("t2_busy12", dut.u_sb.busy_q[12], 1);
        check("t2_idle", o_state, IDLE);

        // addi x13,x12,12 stalls on x12 until writeback.
        i_ex_ready = 0;
        i_if_valid = 1;
        cycle();
        i_if_valid = 0;
        set_insn(32'h00c60693, 32'h24, 1, 0, 1);
        i_de_done = 1;
        cycle();
        i_de_done = 0;
        repeat (3) cycle();
        check("t3_stall", o_state, CHECK);
        check("t3_no_valid", o_issue_valid, 0);
        i_wb_valid = 1; i_wb_rd = 12;
        cycle();
        i_wb_valid = 0;
        check("t3_issue", o_issue_valid, 1);
        check("t3_rd", o_issue_rd, 13);

        // Backpressure: payload held, no busy until accept.
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("t4_valid", o_issue_valid, 1);
            check("t4_pc", o_issue_pc, 32'h24);
            check("t4_busy13", dut.u_sb.busy_q[13], 0);
        end
        i_ex_ready = 1;
        cycle();
        i_ex_ready = 0;
        check("t4_busy13_set", dut.u_sb.busy_q[13], 1);
        check("t4_done", o_issue_valid, 0);

        // Flush while waiting on decoder -> DRAIN, late done dropped.
        i_if_valid = 1;
        cycle();
        i_if_valid = 0;
        i_flush = 1;
        cycle();
        i_flush = 0;
        check("t5_drain", o_state, DRAIN);
        cycle();
        check("t5_drain_hold", o_state, DRAIN);
        set_regs(0, 0, 7, 0, 0, 1, 32'h30);
        i_de_done = 1;
        cycle();
        i_de_done = 0;
        check("t5_idle", o_state, IDLE);
        cycle();
        check("t5_no_issue", o_issue_valid, 0);

        // Flush beats ex_ready in ISSUE.
        set_regs(0, 0, 20, 0, 0, 1, 32'h40);
        i_if_valid = 1;
        cycle();
        i_if_valid = 0;
        i_de_done = 1;
        cycle();
        i_de_done = 0;
        cycle();
        check("t5_issue", o_issue_valid, 1);
        i_flush = 1; i_ex_ready = 1;
        cycle();
        i_flush = 0; i_ex_ready = 0;
        check("t5_busy20", dut.u_sb.busy_q[20], 0);
        check("t5_flush_idle", o_state, IDLE);

        // Write to x0 never marks busy.
        set_insn(32'h00000013, 32'h50, 1, 0, 1);
        i_if_valid = 1;
        cycle();
        i_if_valid = 0;
        i_de_done = 1;
        cycle();
        i_de_done = 0;
        cycle();
        i_ex_ready = 1;
        cycle();
        i_ex_ready = 0;
        check("t6_busy0", dut.u_sb.busy_q[0], 0);

        // Same-cycle set and clear of x5: set wins.
        set_regs(0, 0, 5, 0, 0, 1, 32'h60);
        i_if_valid = 1;
        cycle();
        i_if_valid = 0;
        i_de_done = 1;
        cycle();
        i_de_done = 0;
        cycle();
        i_ex_ready = 1; i_wb_valid = 1; i_wb_rd = 5;
        cycle();
        i_ex_ready = 0; i_wb_valid = 0;
        check("t6_busy5", dut.u_sb.busy_q[5], 1);
`ifdef ISSUE_PERF_CNT_EN
        check("t6_issue_cnt", o_issue_cnt, 4);
        check("t6_stall_cnt", o_stall_cnt, 3);
`endif

        // Randomized traffic with a decoder that answers 0..3 cycles after start.
        clear_inputs();
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                i_reset = 1;
                #1;
                model_reset();
                dec_cnt = -1;
                compare_all();
                @(posedge i_clk);
                @(negedge i_clk);
                compare_all();
                i_reset = 0;
            end
            i_flush    = ($urandom_range(0, 31) == 0);
            i_if_valid = ($urandom_range(0, 3) != 0);
            i_ex_ready = $urandom_range(0, 1);
            i_wb_valid = ($urandom_range(0, 3) == 0);
            i_wb_rd    = 5'($urandom_range(0, 7));
            if (m_start) dec_cnt = $urandom_range(0, 3);
            i_de_done = 0;
            if (dec_cnt == 0) begin
                i_de_done = 1;
                set_regs(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         $urandom());
                dec_cnt = -1;
            end else if (dec_cnt > 0) begin
                dec_cnt--;
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
